// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl
// Four-digit BCD stopwatch controller. A programmable prescaler turns the
// system clock into a count tick. A run/pause/idle FSM gates that tick into a
// cascade of mod-10 digits. A lap register snapshots the live count on demand.
//
// Ports:
//   clk        system clock, rising edge active
//   rst_n      asynchronous active-low reset
//   start      run command (level, sampled every edge)
//   stop       pause command
//   clear      return-to-zero / idle command
//   lap        lap capture command
//   digits     live count, 4 BCD digits, [3:0] = units .. [15:12] = thousands
//   lap_val    last captured count, BCD
//   lap_valid  one-cycle pulse after a capture
//   running    high while the FSM is in RUN
//   ovf        sticky flag, set on the 9999 -> 0000 wrap
module bcd_stopwatch_ctrl #(
   parameter int TICK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] digits,
   output logic [15:0] lap_val,
   output logic        lap_valid,
   output logic        running,
   output logic        ovf
);

   // A divide-by-one prescaler still needs one bit to exist as a register.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic          tick;
   logic [15:0]   digits_inc;
   logic          carry;
   logic          wrap;

   // A tick only exists while running and the prescaler sits at its last value.
   assign tick    = (state == RUN) && (presc == PRESC_MAX);
   assign wrap    = (digits == 16'h9999);
   assign running = (state == RUN);

   // Ripple the carry from the units digit upward: a digit advances only when
   // every digit below it is 9, and any 9 that is carried through returns to 0.
   always_comb begin
      digits_inc = digits;
      carry      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (digits[4*i +: 4] == 4'd9) begin
               digits_inc[4*i +: 4] = 4'd0;
            end else begin
               digits_inc[4*i +: 4] = digits[4*i +: 4] + 4'd1;
               carry                = 1'b0;
            end
         end
      end
   end

   // Main sequencer. The lap capture is evaluated independently of the
   // command priority so a capture on a CLEAR edge still sees the pre-clear
   // count. In RUN the prescaler and digits advance even on a STOP edge, so a
   // STOP that lands on a tick keeps its increment and leaves the prescaler at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         presc     <= '0;
         digits    <= 16'h0000;
         lap_val   <= 16'h0000;
         lap_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         lap_valid <= 1'b0;
         if (lap && (state != IDLE)) begin
            lap_val   <= digits;
            lap_valid <= 1'b1;
         end

         if (clear && (state != IDLE)) begin
            state  <= IDLE;
            presc  <= '0;
            digits <= 16'h0000;
            ovf    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= RUN;
                     presc <= '0;
                  end
               end
               RUN: begin
                  if (tick) begin
                     presc  <= '0;
                     digits <= digits_inc;
                     if (wrap) begin
                        ovf <= 1'b1;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
                  if (stop) begin
                     state <= PAUSE;
                  end
               end
               PAUSE: begin
                  // STOP outranks START, so both together keep us paused.
                  if (start && !stop) begin
                     state <= RUN;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl
// Drives two stopwatch instances (TICK_DIV = 4 and TICK_DIV = 1) from the same
// command inputs. An integer-count model of the stopwatch is compared against
// both instances every cycle, and directed scenarios pin hand-computed values.
module tb_bcd_stopwatch_ctrl;

   localparam int MIDLE  = 0;
   localparam int MRUN   = 1;
   localparam int MPAUSE = 2;

   logic clk;
   logic rst_n;
   logic start;
   logic stop;
   logic clear;
   logic lap;

   logic [15:0] dDigits [2];
   logic [15:0] dLapVal [2];
   logic        dLapValid [2];
   logic        dRunning [2];
   logic        dOvf [2];

   int checks;
   int errors;

   int divs [2];
   int mMode [2];
   int mPresc [2];
   int mCount [2];
   int mLap [2];
   bit mLapValid [2];
   bit mOvf [2];

   bcd_stopwatch_ctrl #(.TICK_DIV(4)) uDiv4 (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stop(stop),
      .clear(clear),
      .lap(lap),
      .digits(dDigits[0]),
      .lap_val(dLapVal[0]),
      .lap_valid(dLapValid[0]),
      .running(dRunning[0]),
      .ovf(dOvf[0])
   );

   bcd_stopwatch_ctrl #(.TICK_DIV(1)) uDiv1 (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stop(stop),
      .clear(clear),
      .lap(lap),
      .digits(dDigits[1]),
      .lap_val(dLapVal[1]),
      .lap_valid(dLapValid[1]),
      .running(dRunning[1]),
      .ovf(dOvf[1])
   );

   // Free-running system clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Converts a plain integer count into four packed BCD digits.
   function automatic logic [15:0] toBcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advances the model of one instance by one clock edge using the commands
   // present before that edge.
   task automatic modelStep(input int i);
      bit tick;
      tick = (mMode[i] == MRUN) && (mPresc[i] == divs[i] - 1);
      if (lap && mMode[i] != MIDLE) begin
         mLap[i]      = mCount[i];
         mLapValid[i] = 1'b1;
      end else begin
         mLapValid[i] = 1'b0;
      end
      if (clear && mMode[i] != MIDLE) begin
         mMode[i]  = MIDLE;
         mCount[i] = 0;
         mPresc[i] = 0;
         mOvf[i]   = 1'b0;
      end else if (mMode[i] == MRUN) begin
         if (tick) begin
            mPresc[i] = 0;
            if (mCount[i] == 9999) mOvf[i] = 1'b1;
            mCount[i] = (mCount[i] + 1) % 10000;
         end else begin
            mPresc[i] = mPresc[i] + 1;
         end
         if (stop) mMode[i] = MPAUSE;
      end else if (mMode[i] == MIDLE) begin
         if (start) begin
            mMode[i]  = MRUN;
            mPresc[i] = 0;
         end
      end else begin
         if (start && !stop) mMode[i] = MRUN;
      end
   endtask

   // Model state follows the DUTs edge by edge, including the async reset.
   initial begin
      divs[0] = 4;
      divs[1] = 1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mMode[i]      = MIDLE;
            mPresc[i]     = 0;
            mCount[i]     = 0;
            mLap[i]       = 0;
            mLapValid[i]  = 1'b0;
            mOvf[i]       = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) modelStep(i);
      end
   end

   // Every falling edge, both instances are compared against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("model digits[%0d]", i), dDigits[i], toBcd(mCount[i]));
         checkOutput($sformatf("model lap_val[%0d]", i), dLapVal[i], toBcd(mLap[i]));
         checkOutput($sformatf("model lap_valid[%0d]", i), 16'(dLapValid[i]), 16'(mLapValid[i]));
         checkOutput($sformatf("model running[%0d]", i), 16'(dRunning[i]), 16'(mMode[i] == MRUN));
         checkOutput($sformatf("model ovf[%0d]", i), 16'(dOvf[i]), 16'(mOvf[i]));
      end
   end

   // Presents one set of commands for exactly one rising edge, then releases them.
   task automatic applyStimulus(input logic st, input logic sp, input logic cl, input logic lp);
      start = st;
      stop  = sp;
      clear = cl;
      lap   = lp;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
      lap   = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Directed scenarios with hand-computed expectations for the divide-by-4
   // instance (index 0) and the divide-by-1 instance (index 1).
   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      clear  = 1'b0;
      lap    = 1'b0;
      idleCycles(2);
      checkOutput("reset digits", dDigits[0], 16'h0000);
      checkOutput("reset running", 16'(dRunning[0]), 16'h0000);
      rst_n = 1'b1;
      idleCycles(1);

      // Count to 25 ticks, then pull reset low mid-cycle.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(100);
      checkOutput("pre-reset digits", dDigits[0], 16'h0025);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async reset digits", dDigits[0], 16'h0000);
      checkOutput("async reset digits div1", dDigits[1], 16'h0000);
      checkOutput("async reset running", 16'(dRunning[0]), 16'h0000);
      checkOutput("async reset ovf", 16'(dOvf[0]), 16'h0000);
      checkOutput("async reset lap_val", dLapVal[0], 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(2);
      checkOutput("idle after reset", 16'(dRunning[0]), 16'h0000);

      // Basic count: first change exactly 4 cycles after START.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("running after start", 16'(dRunning[0]), 16'h0001);
      idleCycles(3);
      checkOutput("no change before 4th", dDigits[0], 16'h0000);
      idleCycles(1);
      checkOutput("first increment", dDigits[0], 16'h0001);
      idleCycles(36);
      checkOutput("basic count 40", dDigits[0], 16'h0010);
      checkOutput("basic count div1", dDigits[1], 16'h0040);
      checkOutput("basic ovf", 16'(dOvf[0]), 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("clear digits", dDigits[0], 16'h0000);

      // Pause / resume: prescaler held at 2, next increment 2 cycles after resume.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("pause digits", dDigits[0], 16'h0001);
      checkOutput("pause running", 16'(dRunning[0]), 16'h0000);
      idleCycles(20);
      checkOutput("held during pause", dDigits[0], 16'h0001);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("resume edge", dDigits[0], 16'h0001);
      idleCycles(1);
      checkOutput("resume +1", dDigits[0], 16'h0001);
      idleCycles(1);
      checkOutput("resume +2", dDigits[0], 16'h0002);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // Lap on a tick edge at 7.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(31);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lap value", dLapVal[0], 16'h0007);
      checkOutput("lap valid", 16'(dLapValid[0]), 16'h0001);
      checkOutput("lap digits", dDigits[0], 16'h0008);
      idleCycles(1);
      checkOutput("lap valid drops", 16'(dLapValid[0]), 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lap in idle", 16'(dLapValid[0]), 16'h0000);
      checkOutput("lap kept in idle", dLapVal[0], 16'h0007);

      // STOP on a tick edge keeps the increment and zeroes the prescaler.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(3);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("stop on tick", dDigits[0], 16'h0001);
      idleCycles(8);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(3);
      checkOutput("resume from 0 +3", dDigits[0], 16'h0001);
      idleCycles(1);
      checkOutput("resume from 0 +4", dDigits[0], 16'h0002);

      // START and STOP together while paused stay paused.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("start+stop in pause", 16'(dRunning[0]), 16'h0000);

      // CLEAR with START while running goes to idle at zero.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("clear+start running", 16'(dRunning[0]), 16'h0000);
      checkOutput("clear+start digits", dDigits[0], 16'h0000);

      // CLEAR with LAP on a tick edge captures the pre-clear count.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(11);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("clear+lap value", dLapVal[0], 16'h0002);
      checkOutput("clear+lap valid", 16'(dLapValid[0]), 16'h0001);
      checkOutput("clear+lap digits", dDigits[0], 16'h0000);

      // Wrap on the divide-by-1 instance.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(999);
      checkOutput("wrap 0999", dDigits[1], 16'h0999);
      idleCycles(1);
      checkOutput("wrap 1000", dDigits[1], 16'h1000);
      idleCycles(8999);
      checkOutput("wrap 9999", dDigits[1], 16'h9999);
      checkOutput("ovf before wrap", 16'(dOvf[1]), 16'h0000);
      idleCycles(1);
      checkOutput("wrap 0000", dDigits[1], 16'h0000);
      checkOutput("ovf at wrap", 16'(dOvf[1]), 16'h0001);
      idleCycles(5);
      checkOutput("count after wrap", dDigits[1], 16'h0005);
      checkOutput("ovf sticky", 16'(dOvf[1]), 16'h0001);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("clear after wrap digits", dDigits[1], 16'h0000);
      checkOutput("clear after wrap ovf", 16'(dOvf[1]), 16'h0000);
      checkOutput("clear after wrap running", 16'(dRunning[1]), 16'h0000);

      idleCycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
